seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the Basys3 4-digit seven-segment display. Holds a 16-bit value (four hex digits), cycles the digit select through all four digits at a programmable rate, drives the active-low anodes and the decoded active-low segments, and inserts a ghosting blank at each digit change. New values are double-buffered and only become visible at a frame boundary, so a frame never shows digits from two different values. Sits between the adder/sum logic and the board display pins.

## Interface

- DIV_CYCLES, 100000, clocks per digit slot; legal range ≥ 4 (100 MHz gives a 1 kHz digit rate and a 250 Hz frame rate).
- BLANK_CYCLES, 1000, clocks at the start of each slot during which all anodes are off; legal range 1 ≤ BLANK_CYCLES < DIV_CYCLES.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scanning; 0 = display dark and counters held.
- load  in  1  single-cycle strobe that captures data_in.
- data_in  in  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- an  out  4  anodes, active-low, one-hot-low while lit.
- seg  out  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.
- digit_sel  out  2  current digit index d.
- pending  out  1  shadow holds a value not yet displayed.
- frame_done  out  1  one-cycle pulse when a new frame starts.

## Operation

- State: prescaler p, width $clog2(DIV_CYCLES), counting 0..DIV_CYCLES-1; digit d, 2 bits; shadow[15:0]; active[15:0]; pending.
- When enable=1, p increments every clock. At terminal count (p = DIV_CYCLES-1), p returns to 0 and d increments mod 4 (3 wraps to 0).
- Frame boundary = terminal count with d = 3. At a boundary, active <= shadow if pending=1, then pending clears; frame_done pulses.
- When load=1, shadow <= data_in and pending <= 1. A load while pending is already set overwrites shadow (last write wins), so an intermediate value is never displayed.
- If load and a boundary occur in the same cycle, active <= data_in directly and pending stays 0.
- Lit window: p ≥ BLANK_CYCLES. In that window an = ~(4'b0001 << d). Outside it, an = 4'b1111.
- seg = hex decode of active[4d+3:4d]. Examples: 0→1000000, 1→1111001, 4→0011001, 8→0000000, A→0001000, F→0001110.
- When enable=0, p and d are held at 0, an = 1111, seg = 1111111, and frame_done = 0. A load writes active directly and pending stays 0. When enable returns to 1, scanning restarts at d = 0, p = 0, beginning with the blank window.

## Timing

- Reset values: p = 0, d = 0, shadow = 0, active = 0, pending = 0, an = 1111, seg = 1111111, digit_sel = 0, frame_done = 0.
- an, seg and frame_done are registered and lag the internal p/d state by one clock. digit_sel = d with no lag.
- pending rises the cycle after the load.
- Per slot: BLANK_CYCLES clocks dark, then DIV_CYCLES-BLANK_CYCLES clocks lit. A frame is 4·DIV_CYCLES clocks.
- Worst-case latency from load to first lit segment of the new value: 4·DIV_CYCLES + BLANK_CYCLES + 1 clocks.
- Reset asserted mid-operation clears all state immediately and asynchronously, including a pending load, and the display goes dark.

## Configuration

- LEADING_ZERO_BLANK_EN defined: any digit above the most-significant nonzero digit of active keeps an = 1111 for its whole slot. Digit 0 is always lit, so active = 0 shows a single "0". d still advances through all four slots, so frame timing is unchanged.
- LEADING_ZERO_BLANK_EN undefined: all four digits are lit, with leading zeros shown as "0".

## Test plan

All directed tests use DIV_CYCLES=8, BLANK_CYCLES=2.

- Reset: pulse rst_n low asynchronously between edges -> all outputs immediately at their reset values; an stays 1111 while enable=0.
- Scan: enable=1, load 0x1234 -> after the first boundary, an cycles 1110→1101→1011→0111, each lit 6 clocks after 2 dark. seg shows 0011001 during digit 0 and 1111001 during digit 3. frame_done pulses every 32 clocks.
- Tear-free update: mid-frame, load 0xABCD then 0x5678 before the boundary -> pending=1, display stays 1234 for the rest of the frame. From the next frame it shows 5678; ABCD never appears.
- Simultaneous event: load 0x00FF in the boundary cycle -> pending stays 0, and the next frame shows 00FF.
- Enable drop: deassert enable during digit 2 -> next clock an=1111, seg=1111111. Re-enable -> d=0 with 2 dark clocks, then digit 0 is lit.
- Macro: active=0x0042 -> with LEADING_ZERO_BLANK_EN, an stays 1111 during slots 2 and 3. Without it, those slots show seg=1000000.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with double-buffered value and blanking.
// Optional macro LEADING_ZERO_BLANK_EN keeps digits above the most-significant nonzero digit dark.
module seg_scan_ctrl #(
    parameter int DIV_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  digit_sel,
    output logic        pending,
    output logic        frame_done
);

    localparam int PW = $clog2(DIV_CYCLES);
    localparam logic [PW-1:0] P_LAST  = PW'(DIV_CYCLES - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic          terminal;
    logic          boundary;
    logic [3:0]    nib;
    logic          digit_on;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign terminal = (p_q == P_LAST);
    assign boundary = enable && terminal && (d_q == 2'd3);
    assign nib      = active_q[{d_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] msd;
    always_comb begin
        msd = 2'd0;
        if (active_q[7:4]   != 4'h0) msd = 2'd1;
        if (active_q[11:8]  != 4'h0) msd = 2'd2;
        if (active_q[15:12] != 4'h0) msd = 2'd3;
        digit_on = (d_q <= msd);
    end
`else
    assign digit_on = 1'b1;
`endif

    always_comb begin
        p_d          = p_q;
        d_d          = d_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        an_d         = 4'hF;
        seg_d        = 7'h7F;
        frame_done_d = boundary;

        if (!enable) begin
            // Idle: loads bypass the shadow since nothing is on screen to tear.
            p_d = '0;
            d_d = 2'd0;
            if (load) begin
                shadow_d  = data_in;
                active_d  = data_in;
                pending_d = 1'b0;
            end
        end else begin
            p_d = terminal ? '0 : p_q + 1'b1;
            d_d = terminal ? d_q + 2'd1 : d_q;
            if (boundary) begin
                if (load) begin
                    shadow_d  = data_in;
                    active_d  = data_in;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end else if (load) begin
                shadow_d  = data_in;
                pending_d = 1'b1;
            end
            seg_d = hex7(nib);
            if ((p_q >= P_BLANK) && digit_on) an_d = ~(4'b0001 << d_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q          <= '0;
            d_q          <= 2'd0;
            shadow_q     <= 16'h0;
            active_q     <= 16'h0;
            pending_q    <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            d_q          <= d_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign digit_sel  = d_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIV_CYCLES=8, BLANK_CYCLES=2; expected lit slots are queued per frame
// and popped by a monitor at each lit-slot start. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_sel;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    seg_scan_ctrl #(.DIV_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .an         (an),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .pending    (pending),
        .frame_done (frame_done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout reached before end of test");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b1000000;
            4'h1: seg_of = 7'b1111001;
            4'h2: seg_of = 7'b0100100;
            4'h3: seg_of = 7'b0110000;
            4'h4: seg_of = 7'b0011001;
            4'h5: seg_of = 7'b0010010;
            4'h6: seg_of = 7'b0000010;
            4'h7: seg_of = 7'b1111000;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0010000;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b0000011;
            4'hC: seg_of = 7'b1000110;
            4'hD: seg_of = 7'b0100001;
            4'hE: seg_of = 7'b0000110;
            default: seg_of = 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue the lit slots of the first n digit slots of a frame showing v.
    task automatic push_frame(input logic [15:0] v, input int n);
        logic [3:0] a;
`ifdef LEADING_ZERO_BLANK_EN
        int top = 0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) top = i;
`endif
        for (int i = 0; i < n; i++) begin
            a = 4'b1111;
            a[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (i <= top) exp_q.push_back({a, seg_of(v[4*i +: 4])});
`else
            exp_q.push_back({a, seg_of(v[4*i +: 4])});
`endif
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", frame_done, 1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor / scoreboard
    logic [3:0]  prev_an = 4'hF;
    logic [10:0] cur_exp = '0;
    int run_len = 0;
    int cyc = 0;
    int last_fd = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n || !enable) last_fd = -1;
        else if (frame_done) begin
            if (last_fd >= 0) begin
                checks++;
                if (cyc - last_fd != 32) begin
                    errors++;
                    $display("FAIL frame_period actual=%0d expected=32", cyc - last_fd);
                end
            end
            last_fd = cyc;
        end
        if (an != 4'hF) begin
            checks++;
            if (an != prev_an) begin
                run_len = 1;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_unexpected actual an=%b seg=%b expected none", an, seg);
                    cur_exp = {an, seg};
                end else begin
                    cur_exp = exp_q.pop_front();
                    if ({an, seg} !== cur_exp)
                        begin
                            errors++;
                            $display("FAIL slot_start actual an=%b seg=%b expected an=%b seg=%b",
                                     an, seg, cur_exp[10:7], cur_exp[6:0]);
                        end
                end
            end else begin
                run_len++;
                if ({an, seg} !== cur_exp) begin
                    errors++;
                    $display("FAIL slot_hold actual an=%b seg=%b expected an=%b seg=%b",
                             an, seg, cur_exp[10:7], cur_exp[6:0]);
                end
            end
        end else if (prev_an != 4'hF && rst_n && enable) begin
            checks++;
            if (run_len != 6) begin
                errors++;
                $display("FAIL slot_len actual=%0d expected=6", run_len);
            end
        end
        prev_an = an;
    end

    // driver
    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        data_in = 16'h0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_pending", pending, 0);
        chk("rst_frame_done", frame_done, 0);
        tick(3);
        chk("idle_an", an, 4'hF);

        // Scan: first frame shows 0000, then 1234 after the boundary.
        push_frame(16'h0000, 4);
        push_frame(16'h1234, 4);
        enable  = 1'b1;
        load    = 1'b1;
        data_in = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        chk("scan_pending_set", pending, 1);
        wait_frame();
        chk("scan_pending_clr", pending, 0);

        // Tear-free: ABCD is overwritten by 5678 before the boundary.
        tick(5);
        load    = 1'b1;
        data_in = 16'hABCD;
        @(negedge clk);
        data_in = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        chk("tear_pending", pending, 1);
        push_frame(16'h5678, 4);
        wait_frame();
        chk("tear_pending_clr", pending, 0);

        // Load in the boundary cycle (d=3, p=7).
        tick(31);
        chk("bnd_digit_sel", digit_sel, 3);
        push_frame(16'h00FF, 3);
        load    = 1'b1;
        data_in = 16'h00FF;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_frame_done", frame_done, 1);
        chk("bnd_pending", pending, 0);

        // Enable drop mid digit 2.
        tick(20);
        chk("drop_digit_sel", digit_sel, 2);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_an", an, 4'hF);
        chk("drop_seg", seg, 7'h7F);
        chk("drop_digit_sel0", digit_sel, 0);
        chk("drop_frame_done", frame_done, 0);
        tick(3);
        push_frame(16'h00FF, 4);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_dark1", an, 4'hF);
        chk("reen_digit_sel", digit_sel, 0);
        @(negedge clk);
        chk("reen_dark2", an, 4'hF);
        @(negedge clk);
        chk("reen_lit_an", an, 4'b1110);
        chk("reen_lit_seg", seg, 7'b0001110);
        wait_frame();
        enable = 1'b0;

        // Leading-zero case: direct load while idle.
        tick(2);
        load    = 1'b1;
        data_in = 16'h0042;
        @(negedge clk);
        load = 1'b0;
        chk("idle_load_pending", pending, 0);
        push_frame(16'h0042, 4);
        enable = 1'b1;
        wait_frame();
        enable = 1'b0;

        // Asynchronous reset between edges discards a pending load.
        tick(2);
        enable  = 1'b1;
        load    = 1'b1;
        data_in = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        chk("pre_rst_pending", pending, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_pending", pending, 0);
        chk("arst_digit_sel", digit_sel, 0);
        chk("arst_frame_done", frame_done, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 4);
        push_frame(16'h0000, 4);
        enable = 1'b1;
        wait_frame();
        wait_frame();
        enable = 1'b0;
        tick(4);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
